ram_boot_loader: RTL and testbench

//  Sits between the processor toplevel and the ram on the memory bus. After

---
 rtl/ram_boot_loader_pkg.sv | 23 ++
 rtl/ram_boot_loader_if.sv | 42 ++++
 rtl/ram_boot_loader.sv | 97 +++++++++
 tb/tb_ram_boot_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_boot_loader_pkg.sv
// Shared types and defaults for the ram boot loader: state encoding, bus
// widths and the read/write level helper.
package ram_boot_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam int   ADDR_W_DEF   = 8;
  localparam int   DATA_W_DEF   = 8;
  localparam int   IWORD_W_DEF  = 16;
  localparam int   LOAD_LEN_DEF = 256;
  localparam logic RW_WRITE_DEF = 1'b0;

  // The read level is always the opposite of the write level.
  function automatic logic rw_read_level(input logic rw_write);
    return ~rw_write;
  endfunction

endpackage

// File: rtl/ram_boot_loader_if.sv
// Bus bundle around the boot loader: byte stream in, processor side, ram side.
// slave = the loader, master = whatever surrounds it (processor, ram, stream).
interface ram_boot_loader_if
  import ram_boot_loader_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int IWORD_W = IWORD_W_DEF
) ();

  logic               boot_skip;
  // Stream handshake: a byte moves on every rising edge where ld_valid and
  // ld_ready are both high; ld_data/ld_last are only meaningful with ld_valid,
  // and ld_ready never depends on ld_valid in the same cycle.
  logic               ld_valid;
  logic [DATA_W-1:0]  ld_data;
  logic               ld_last;
  logic               ld_ready;
  logic [ADDR_W-1:0]  cpu_adrs;
  logic [DATA_W-1:0]  cpu_dout;
  logic               cpu_rw;
  logic [IWORD_W-1:0] cpu_din;
  logic               cpu_run;
  logic [ADDR_W-1:0]  ram_adrs;
  logic [DATA_W-1:0]  ram_din;
  logic               ram_rw;
  logic [IWORD_W-1:0] ram_dout;
  logic [ADDR_W:0]    load_cnt;

  modport slave (
    input  boot_skip, ld_valid, ld_data, ld_last,
    input  cpu_adrs, cpu_dout, cpu_rw, ram_dout,
    output ld_ready, cpu_din, cpu_run, ram_adrs, ram_din, ram_rw, load_cnt
  );

  modport master (
    output boot_skip, ld_valid, ld_data, ld_last,
    output cpu_adrs, cpu_dout, cpu_rw, ram_dout,
    input  ld_ready, cpu_din, cpu_run, ram_adrs, ram_din, ram_rw, load_cnt
  );

endinterface

// File: rtl/ram_boot_loader.sv
// Boot loader: fills ram from a byte stream at ascending addresses while the
// processor is held, then passes the memory bus straight through to it.
module ram_boot_loader
  import ram_boot_loader_pkg::*;
#(
  parameter int   ADDR_W   = ADDR_W_DEF,
  parameter int   DATA_W   = DATA_W_DEF,
  parameter int   IWORD_W  = IWORD_W_DEF,
  parameter int   LOAD_LEN = LOAD_LEN_DEF,
  parameter logic RW_WRITE = RW_WRITE_DEF
) (
  input  logic             clk,
  input  logic             clr,
  ram_boot_loader_if.slave bus,
  output state_t           dbg_state
);

  localparam logic              RW_READ   = rw_read_level(RW_WRITE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_LEN - 1);
  localparam logic [ADDR_W:0]   MAX_CNT   = (ADDR_W + 1)'(LOAD_LEN);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              wr_pend_q;
  logic [ADDR_W-1:0] wr_adrs_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              accept;
  logic              last_accept;

  assign accept      = bus.ld_valid & (state_q == ST_LOAD);
  assign last_accept = accept & (bus.ld_last | (addr_q == LAST_ADDR));

  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = bus.boot_skip ? ST_RUN : ST_LOAD;
      ST_LOAD:  if (last_accept) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Write pipeline: an accepted byte is driven to ram the cycle after it is
  // taken, and counted on the edge where ram commits it.
  always_ff @(posedge clk) begin
    if (clr) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_pend_q <= 1'b0;
      wr_adrs_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_pend_q <= accept;
      if (accept) begin
        wr_adrs_q <= addr_q;
        wr_data_q <= bus.ld_data;
        if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
      end
      if (wr_pend_q && (cnt_q != MAX_CNT)) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    bus.ld_ready = 1'b0;
    bus.cpu_run  = 1'b0;
    bus.ram_adrs = '0;
    bus.ram_din  = '0;
    bus.ram_rw   = RW_READ;
    case (state_q)
      ST_LOAD, ST_FLUSH: begin
        bus.ld_ready = (state_q == ST_LOAD);
        bus.ram_adrs = wr_adrs_q;
        bus.ram_din  = wr_data_q;
        // clr gates the strobe so a write still in flight never reaches ram.
        bus.ram_rw   = (wr_pend_q & ~clr) ? RW_WRITE : RW_READ;
      end
      ST_RUN: begin
        bus.cpu_run  = 1'b1;
        bus.ram_adrs = bus.cpu_adrs;
        bus.ram_din  = bus.cpu_dout;
        bus.ram_rw   = bus.cpu_rw;
      end
      default: ;
    endcase
  end

  assign bus.cpu_din  = bus.ram_dout;
  assign bus.load_cnt = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ram_boot_loader.sv
// Testbench for ram_boot_loader: directed and randomized byte streams against
// a stream-level model, a behavioural ram, and a write scoreboard.
module tb_ram_boot_loader;
  import ram_boot_loader_pkg::*;

  localparam int   LOAD_LEN = 8;
  localparam logic WR       = 1'b0;
  localparam logic RD       = 1'b1;
  localparam int   W        = 32;

  logic   clk = 1'b0;
  logic   clr = 1'b1;
  state_t dbg_state;
  int     cyc = 0;

  ram_boot_loader_if #(.ADDR_W(8), .DATA_W(8), .IWORD_W(16)) bif ();

  ram_boot_loader #(
    .ADDR_W(8), .DATA_W(8), .IWORD_W(16), .LOAD_LEN(LOAD_LEN), .RW_WRITE(WR)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bif),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural ram ----------------
  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];

  assign bif.ram_dout = {~mem[bif.ram_adrs], mem[bif.ram_adrs]};

  always @(posedge clk)
    if (bif.ram_rw === WR) mem[bif.ram_adrs] <= bif.ram_din;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always @(negedge clk)
    if (bif.ram_rw === WR) got_q.push_back({16'(cyc), bif.ram_adrs, bif.ram_din});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write must land in the expected cycle, address and data.
  task automatic compare_logs(input string tag);
    chk({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_write"}, got_q[i], exp_q[i]);
    foreach (exp_q[i]) exp_mem[exp_q[i][15:8]] = exp_q[i][7:0];
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_mem(input string tag, input int n);
    for (int i = 0; i < n; i++) chk({tag, "_mem"}, 32'(mem[i]), 32'(exp_mem[i]));
  endtask

  // ---------------- stream-level reference model ----------------
  int m_acc;
  int m_load_from;
  int m_run_at;
  bit m_ended;

  function automatic logic exp_ready();
    return (cyc >= m_load_from) && !m_ended;
  endfunction

  function automatic logic exp_run();
    return (m_run_at >= 0) && (cyc >= m_run_at);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_checks();
    chk("ld_ready", 32'(bif.ld_ready), 32'(exp_ready()));
    chk("cpu_run", 32'(bif.cpu_run), 32'(exp_run()));
  endtask

  task automatic gap();
    bif.ld_valid = 1'b0;
    bif.ld_last  = 1'b0;
    cycle_checks();
    tick();
  endtask

  task automatic offer(input logic [7:0] data, input logic last);
    bit take;
    bif.ld_valid = 1'b1;
    bif.ld_data  = data;
    bif.ld_last  = last;
    take = exp_ready();
    cycle_checks();
    if (take) begin
      exp_q.push_back({16'(cyc + 1), 8'(m_acc), data});
      m_acc++;
      if (last || m_acc == LOAD_LEN) begin
        m_ended  = 1'b1;
        m_run_at = cyc + 2;
      end
    end
    tick();
    bif.ld_valid = 1'b0;
    bif.ld_last  = 1'b0;
  endtask

  task automatic do_reset(input logic skip);
    clr           = 1'b1;
    bif.boot_skip = skip;
    bif.ld_valid  = 1'b0;
    bif.ld_last   = 1'b0;
    bif.cpu_rw    = RD;
    // Writes not yet committed when clr rises are lost.
    while (exp_q.size() > 0 && int'(exp_q[$][31:16]) >= cyc) void'(exp_q.pop_back());
    m_acc = 0; m_ended = 1'b0; m_run_at = -1; m_load_from = 1 << 30;
    tick();
    tick();
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_ld_ready", 32'(bif.ld_ready), 32'd0);
    chk("rst_cpu_run", 32'(bif.cpu_run), 32'd0);
    chk("rst_ram_rw", 32'(bif.ram_rw), 32'(RD));
    chk("rst_ram_adrs", 32'(bif.ram_adrs), 32'd0);
    chk("rst_load_cnt", 32'(bif.load_cnt), 32'd0);
    compare_logs("rst");
    clr = 1'b0;
    if (skip) m_run_at = cyc + 1;
    else      m_load_from = cyc + 1;
  endtask

  task automatic finish_load(input string tag);
    for (int k = 0; k < 20 && !exp_run(); k++) gap();
    chk({tag, "_cpu_run"}, 32'(bif.cpu_run), 32'd1);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_RUN));
    chk({tag, "_load_cnt"}, 32'(bif.load_cnt), 32'(m_acc));
    compare_logs(tag);
  endtask

  task automatic cpu_write_read(input logic [7:0] a, input logic [7:0] d);
    bif.cpu_adrs = a;
    bif.cpu_dout = d;
    bif.cpu_rw   = WR;
    #1;
    chk("run_ram_adrs", 32'(bif.ram_adrs), 32'(a));
    chk("run_ram_din", 32'(bif.ram_din), 32'(d));
    chk("run_ram_rw_wr", 32'(bif.ram_rw), 32'(WR));
    exp_q.push_back({16'(cyc), a, d});
    tick();
    bif.cpu_rw = RD;
    #1;
    chk("run_ram_rw_rd", 32'(bif.ram_rw), 32'(RD));
    chk("run_cpu_din", 32'(bif.cpu_din), 32'({~d, d}));
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b4[4];
    int len;
    int last_idx;
    b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33; b4[3] = 8'h44;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'hEE;
      exp_mem[i] = 8'hEE;
    end
    bif.boot_skip = 1'b0;
    bif.ld_valid  = 1'b0;
    bif.ld_data   = '0;
    bif.ld_last   = 1'b0;
    bif.cpu_adrs  = '0;
    bif.cpu_dout  = '0;
    bif.cpu_rw    = RD;

    // 1: back-to-back stream, last on the fourth byte
    do_reset(1'b0);
    gap();
    for (int i = 0; i < 4; i++) offer(b4[i], i == 3);
    finish_load("t1");
    check_mem("t1", 4);

    // 2: same bytes with three idle cycles between each
    do_reset(1'b0);
    gap();
    for (int i = 0; i < 4; i++) begin
      offer(b4[i], i == 3);
      if (i != 3) begin
        gap();
        chk("t2_gap_rw", 32'(bif.ram_rw), 32'(RD));
        gap();
        chk("t2_gap_rw", 32'(bif.ram_rw), 32'(RD));
        gap();
      end
    end
    finish_load("t2");
    check_mem("t2", 4);

    // 3: no last flag, ten bytes offered, length limit ends the load
    do_reset(1'b0);
    gap();
    for (int i = 0; i < 10; i++) offer(8'($urandom), 1'b0);
    finish_load("t3");
    check_mem("t3", 10);

    // 3b: last flag and length limit on the same byte
    do_reset(1'b0);
    gap();
    for (int i = 0; i < 10; i++) offer(8'($urandom), i == 7);
    finish_load("t3b");
    check_mem("t3b", 10);

    // 4: boot_skip goes straight to RUN, stream ignored
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) offer(8'($urandom), i == 3);
    chk("t4_state", 32'(dbg_state), 32'(ST_RUN));
    chk("t4_load_cnt", 32'(bif.load_cnt), 32'd0);
    compare_logs("t4");
    check_mem("t4", 8);

    // 5: clr after two accepts drops the in-flight write, then reload five
    do_reset(1'b0);
    gap();
    offer(8'hA0, 1'b0);
    offer(8'hA1, 1'b0);
    do_reset(1'b0);
    check_mem("t5_drop", 4);
    gap();
    for (int i = 0; i < 5; i++) offer(8'hC0 + 8'(i), i == 4);
    finish_load("t5");
    check_mem("t5", 8);

    // random streams: random lengths, gaps and last position
    for (int r = 0; r < 4; r++) begin
      do_reset(1'b0);
      gap();
      len = $urandom_range(1, 10);
      if (len > LOAD_LEN) last_idx = $urandom_range(0, len);
      else                last_idx = $urandom_range(0, len - 1);
      for (int i = 0; i < len; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) gap();
        offer(8'($urandom), i == last_idx);
      end
      finish_load("rnd");
      check_mem("rnd", 10);
    end

    // 6: processor traffic in RUN passes straight through
    cpu_write_read(8'h10, 8'hAB);
    for (int i = 0; i < 6; i++) cpu_write_read(8'($urandom_range(16, 255)), 8'($urandom));
    bif.cpu_adrs = 8'h10;
    #1;
    chk("t6_readback", 32'(bif.cpu_din), 32'({8'h54, 8'hAB}));
    compare_logs("t6");
    check_mem("t6", 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
